// File: rtl/display_driver_pkg.sv
// Shared definitions for the stopwatch display driver: converter FSM states,
// active-low 7-segment codes {g,f,e,d,c,b,a} and digit index constants.
package display_driver_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    DESLOCA  = 2'd1,
    ATUALIZA = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit index i drives an[i] low.
  localparam logic [1:0] IDX_DECIMOS  = 2'd0;
  localparam logic [1:0] IDX_UNIDADES = 2'd1;
  localparam logic [1:0] IDX_DEZENAS  = 2'd2;
  localparam logic [1:0] IDX_CENTENAS = 2'd3;

  localparam logic [9:0] MAX_SEGUNDOS = 10'd999;
  localparam int         DD_ITERS     = 10;

  // Values above 9 map to a dash; only the tenths digit can ever hold one.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/display_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: 10-bit binary to three BCD digits,
// one shift-add-3 iteration per cycle, result valid while done is high.
module bin2bcd_seq
  import display_driver_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  bin_in,
  output logic [3:0]  bcd_cen,
  output logic [3:0]  bcd_dez,
  output logic [3:0]  bcd_uni,
  output logic        done,
  output logic        busy,
  output conv_state_t state_o
);

  conv_state_t state_q, state_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  iter_q, iter_d;
  logic [11:0] adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    adj     = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    case (state_q)
      OCIOSO: begin
        if (start) begin
          state_d = DESLOCA;
          bin_d   = bin_in;
          bcd_d   = '0;
          iter_d  = '0;
        end
      end
      DESLOCA: begin
        bcd_d  = {adj[10:0], bin_q[9]};
        bin_d  = {bin_q[8:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'(DD_ITERS - 1)) state_d = ATUALIZA;
      end
      ATUALIZA: state_d = OCIOSO;
      default:  state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OCIOSO;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
    end
  end

  assign bcd_cen = bcd_q[11:8];
  assign bcd_dez = bcd_q[7:4];
  assign bcd_uni = bcd_q[3:0];
  assign done    = (state_q == ATUALIZA);
  assign busy    = (state_q != OCIOSO);
  assign state_o = state_q;

endmodule

// File: rtl/display_driver.sv
// Four-digit multiplexed stopwatch display (SSS.d) with a once-per-frame
// binary-to-BCD refresh. Define DISPLAY_BLANK_ZEROS_EN to blank leading zeros.
module display_driver
  import display_driver_pkg::*;
#(
  parameter int CICLOS_DIGITO = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  cont_seg,
  input  logic [3:0]  cont_dec,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        ocupado,
  output conv_state_t estado_dbg
);

  localparam int PW = (CICLOS_DIGITO > 1) ? $clog2(CICLOS_DIGITO) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CICLOS_DIGITO - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    dec_cap_q, dec_cap_d;
  logic [3:0]    cen_q, cen_d, dez_q, dez_d, uni_q, uni_d, dcm_q, dcm_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick, frame_start, busy, done;
  logic [9:0]    seg_sat;
  logic [3:0]    bcd_cen, bcd_dez, bcd_uni;
  logic [6:0]    cen_code, dez_code;

  assign tick        = (presc_q == PRESC_MAX);
  assign frame_start = tick && (idx_q == IDX_CENTENAS);
  assign seg_sat     = (cont_seg > MAX_SEGUNDOS) ? MAX_SEGUNDOS : cont_seg;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .reset   (reset),
    .start   (frame_start),
    .bin_in  (seg_sat),
    .bcd_cen (bcd_cen),
    .bcd_dez (bcd_dez),
    .bcd_uni (bcd_uni),
    .done    (done),
    .busy    (busy),
    .state_o (estado_dbg)
  );

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    // Tenths are captured alongside the seconds so both come from the same instant.
    dec_cap_d = (frame_start && !busy) ? cont_dec : dec_cap_q;
    cen_d     = cen_q;
    dez_d     = dez_q;
    uni_d     = uni_q;
    dcm_d     = dcm_q;
    if (done) begin
      cen_d = bcd_cen;
      dez_d = bcd_dez;
      uni_d = bcd_uni;
      dcm_d = dec_cap_q;
    end

    cen_code = seg_encode(cen_q);
    dez_code = seg_encode(dez_q);
`ifdef DISPLAY_BLANK_ZEROS_EN
    if (cen_q == 4'd0) cen_code = SEG_BLANK;
    if (cen_q == 4'd0 && dez_q == 4'd0) dez_code = SEG_BLANK;
`endif

    an_d  = 4'b1110;
    seg_d = seg_encode(dcm_q);
    case (idx_q)
      IDX_DECIMOS:  begin an_d = 4'b1110; seg_d = seg_encode(dcm_q); end
      IDX_UNIDADES: begin an_d = 4'b1101; seg_d = seg_encode(uni_q); end
      IDX_DEZENAS:  begin an_d = 4'b1011; seg_d = dez_code;          end
      IDX_CENTENAS: begin an_d = 4'b0111; seg_d = cen_code;          end
      default:      begin an_d = 4'b1110; seg_d = seg_encode(dcm_q); end
    endcase
    dp_d = (idx_q != IDX_UNIDADES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= IDX_DECIMOS;
      dec_cap_q <= '0;
      cen_q     <= '0;
      dez_q     <= '0;
      uni_q     <= '0;
      dcm_q     <= '0;
      an_q      <= 4'b1110;
      seg_q     <= SEG_0;
      dp_q      <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      dec_cap_q <= dec_cap_d;
      cen_q     <= cen_d;
      dez_q     <= dez_d;
      uni_q     <= uni_d;
      dcm_q     <= dcm_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign ocupado = busy;

endmodule

// File: tb/tb_display_driver.sv
// Directed bench for display_driver with CICLOS_DIGITO=16: scan order,
// conversion latency, saturation, capture timing, reset abort and blanking.
module tb_display_driver;

  localparam int CICLOS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] cont_seg = '0;
  logic [3:0] cont_dec = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       ocupado;
  logic [1:0] estado_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  display_driver #(.CICLOS_DIGITO(CICLOS)) dut (
    .clk        (clk),
    .reset      (reset),
    .cont_seg   (cont_seg),
    .cont_dec   (cont_dec),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .ocupado    (ocupado),
    .estado_dbg (estado_dbg)
  );

  // Returns at the negedge right after the reset edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ocupado(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ocupado === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Samples ncyc cycles; returns the first seg value seen per digit and
  // the number of samples with a bad dp or an invalid an pattern.
  task automatic capture_frame(input int ncyc, output logic [6:0] s3, output logic [6:0] s2,
                               output logic [6:0] s1, output logic [6:0] s0, output int bad);
    bit seen3 = 0, seen2 = 0, seen1 = 0, seen0 = 0;
    s3 = 'x; s2 = 'x; s1 = 'x; s0 = 'x;
    bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      case (an)
        4'b0111: if (!seen3) begin s3 = seg; seen3 = 1; end
        4'b1011: if (!seen2) begin s2 = seg; seen2 = 1; end
        4'b1101: if (!seen1) begin s1 = seg; seen1 = 1; end
        4'b1110: if (!seen0) begin s0 = seg; seen0 = 1; end
        default: bad++;
      endcase
      if (dp !== ((an == 4'b1101) ? 1'b0 : 1'b1)) bad++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 5;
    if (an !== 4'b1110) begin n_fail++; $display("FAIL reset_an: got %b expected 1110", an); end
    if (seg !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg: got %b expected 1000000", seg); end
    if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", dp); end
    if (ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
    if (estado_dbg !== 2'b00) begin n_fail++; $display("FAIL reset_estado: got %b expected 00", estado_dbg); end
  endtask

  task automatic test_scan();
    int idx;
    logic [3:0] exp_an;
    logic exp_ocup;
    cont_seg = 10'd0;
    cont_dec = 4'd0;
    do_reset();
    for (int k = 0; k <= 80; k++) begin
      idx      = (k == 0) ? 0 : ((k - 1) / CICLOS) % 4;
      exp_an   = ~(4'b0001 << idx);
      exp_ocup = (k >= 64 && k <= 74);
      n_checks += 4;
      if (an !== exp_an) begin n_fail++; $display("FAIL scan_an k=%0d: got %b expected %b", k, an, exp_an); end
      if (seg !== 7'b1000000) begin n_fail++; $display("FAIL scan_seg k=%0d: got %b expected 1000000", k, seg); end
      if (dp !== (exp_an != 4'b1101)) begin n_fail++; $display("FAIL scan_dp k=%0d: got %b expected %b", k, dp, exp_an != 4'b1101); end
      if (ocupado !== exp_ocup) begin n_fail++; $display("FAIL scan_ocupado k=%0d: got %b expected %b", k, ocupado, exp_ocup); end
      @(negedge clk);
    end
  endtask

  task automatic test_convert_427();
    bit ok;
    int hi;
    logic [6:0] s3, s2, s1, s0;
    int bad;
    cont_seg = 10'd427;
    cont_dec = 4'd5;
    do_reset();
    wait_ocupado(1'b1, 200, ok);
    n_checks += 2;
    if (!ok) begin n_fail++; $display("FAIL c427_start: ocupado never rose within 200 cycles"); end
    if (estado_dbg !== 2'b01) begin n_fail++; $display("FAIL c427_estado: got %b expected 01", estado_dbg); end
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ocupado === 1'b1) hi++;
      else break;
    end
    n_checks++;
    if (hi != 11) begin n_fail++; $display("FAIL c427_busy_cycles: got %0d expected 11", hi); end
    capture_frame(56, s3, s2, s1, s0, bad);
    n_checks += 5;
    if (s3 !== 7'b0011001) begin n_fail++; $display("FAIL c427_hund: got %b expected 0011001", s3); end
    if (s2 !== 7'b0100100) begin n_fail++; $display("FAIL c427_tens: got %b expected 0100100", s2); end
    if (s1 !== 7'b1111000) begin n_fail++; $display("FAIL c427_units: got %b expected 1111000", s1); end
    if (s0 !== 7'b0010010) begin n_fail++; $display("FAIL c427_tenths: got %b expected 0010010", s0); end
    if (bad != 0) begin n_fail++; $display("FAIL c427_dp_an: got %0d bad samples expected 0", bad); end
  endtask

  // Runs right after test_convert_427, so the display holds 4,2,7,5.
  task automatic test_reset_mid_conversion();
    bit ok;
    logic [6:0] s3, s2, s1, s0;
    int bad;
    wait_ocupado(1'b1, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_start: ocupado never rose within 200 cycles"); end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks += 5;
    if (an !== 4'b1110) begin n_fail++; $display("FAIL rstmid_an: got %b expected 1110", an); end
    if (seg !== 7'b1000000) begin n_fail++; $display("FAIL rstmid_seg: got %b expected 1000000", seg); end
    if (dp !== 1'b1) begin n_fail++; $display("FAIL rstmid_dp: got %b expected 1", dp); end
    if (ocupado !== 1'b0) begin n_fail++; $display("FAIL rstmid_ocupado: got %b expected 0", ocupado); end
    if (estado_dbg !== 2'b00) begin n_fail++; $display("FAIL rstmid_estado: got %b expected 00", estado_dbg); end
    capture_frame(56, s3, s2, s1, s0, bad);
    n_checks += 4;
    if (s3 !== 7'b1000000) begin n_fail++; $display("FAIL rstmid_hund: got %b expected 1000000", s3); end
    if (s2 !== 7'b1000000) begin n_fail++; $display("FAIL rstmid_tens: got %b expected 1000000", s2); end
    if (s1 !== 7'b1000000) begin n_fail++; $display("FAIL rstmid_units: got %b expected 1000000", s1); end
    if (s0 !== 7'b1000000) begin n_fail++; $display("FAIL rstmid_tenths: got %b expected 1000000", s0); end
  endtask

  task automatic test_saturate();
    bit ok1, ok0;
    logic [6:0] s3, s2, s1, s0;
    int bad;
    cont_seg = 10'd1023;
    cont_dec = 4'd12;
    do_reset();
    wait_ocupado(1'b1, 200, ok1);
    wait_ocupado(1'b0, 40, ok0);
    n_checks++;
    if (!(ok1 && ok0)) begin n_fail++; $display("FAIL sat_conv: conversion not seen, rise=%0b fall=%0b expected 1 1", ok1, ok0); end
    capture_frame(56, s3, s2, s1, s0, bad);
    n_checks += 4;
    if (s3 !== 7'b0010000) begin n_fail++; $display("FAIL sat_hund: got %b expected 0010000", s3); end
    if (s2 !== 7'b0010000) begin n_fail++; $display("FAIL sat_tens: got %b expected 0010000", s2); end
    if (s1 !== 7'b0010000) begin n_fail++; $display("FAIL sat_units: got %b expected 0010000", s1); end
    if (s0 !== 7'b0111111) begin n_fail++; $display("FAIL sat_tenths_dash: got %b expected 0111111", s0); end
  endtask

  task automatic test_capture_hold();
    bit ok1, ok0;
    logic [6:0] s3, s2, s1, s0;
    int bad;
    cont_seg = 10'd123;
    cont_dec = 4'd0;
    do_reset();
    wait_ocupado(1'b1, 200, ok1);
    repeat (3) @(negedge clk);
    cont_seg = 10'd456;
    wait_ocupado(1'b0, 40, ok0);
    n_checks++;
    if (!(ok1 && ok0)) begin n_fail++; $display("FAIL hold_conv1: conversion not seen, rise=%0b fall=%0b expected 1 1", ok1, ok0); end
    capture_frame(56, s3, s2, s1, s0, bad);
    n_checks += 4;
    if (s3 !== 7'b1111001) begin n_fail++; $display("FAIL hold_hund_1: got %b expected 1111001", s3); end
    if (s2 !== 7'b0100100) begin n_fail++; $display("FAIL hold_tens_2: got %b expected 0100100", s2); end
    if (s1 !== 7'b0110000) begin n_fail++; $display("FAIL hold_units_3: got %b expected 0110000", s1); end
    if (s0 !== 7'b1000000) begin n_fail++; $display("FAIL hold_tenths_0: got %b expected 1000000", s0); end
    wait_ocupado(1'b1, 200, ok1);
    wait_ocupado(1'b0, 40, ok0);
    n_checks++;
    if (!(ok1 && ok0)) begin n_fail++; $display("FAIL hold_conv2: conversion not seen, rise=%0b fall=%0b expected 1 1", ok1, ok0); end
    capture_frame(56, s3, s2, s1, s0, bad);
    n_checks += 3;
    if (s3 !== 7'b0011001) begin n_fail++; $display("FAIL hold_hund_4: got %b expected 0011001", s3); end
    if (s2 !== 7'b0010010) begin n_fail++; $display("FAIL hold_tens_5: got %b expected 0010010", s2); end
    if (s1 !== 7'b0000010) begin n_fail++; $display("FAIL hold_units_6: got %b expected 0000010", s1); end
  endtask

  task automatic test_blank_zeros();
    bit ok1, ok0;
    logic [6:0] s3, s2, s1, s0;
    logic [6:0] exp_lead;
    int bad;
`ifdef DISPLAY_BLANK_ZEROS_EN
    exp_lead = 7'b1111111;
`else
    exp_lead = 7'b1000000;
`endif
    cont_seg = 10'd7;
    cont_dec = 4'd0;
    do_reset();
    wait_ocupado(1'b1, 200, ok1);
    wait_ocupado(1'b0, 40, ok0);
    n_checks++;
    if (!(ok1 && ok0)) begin n_fail++; $display("FAIL blank_conv: conversion not seen, rise=%0b fall=%0b expected 1 1", ok1, ok0); end
    capture_frame(56, s3, s2, s1, s0, bad);
    n_checks += 5;
    if (s3 !== exp_lead) begin n_fail++; $display("FAIL blank_hund: got %b expected %b", s3, exp_lead); end
    if (s2 !== exp_lead) begin n_fail++; $display("FAIL blank_tens: got %b expected %b", s2, exp_lead); end
    if (s1 !== 7'b1111000) begin n_fail++; $display("FAIL blank_units: got %b expected 1111000", s1); end
    if (s0 !== 7'b1000000) begin n_fail++; $display("FAIL blank_tenths: got %b expected 1000000", s0); end
    if (bad != 0) begin n_fail++; $display("FAIL blank_dp_an: got %0d bad samples expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_convert_427();
    test_reset_mid_conversion();
    test_saturate();
    test_capture_hold();
    test_blank_zeros();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
